// File: rtl/mahjamma_matrix_scanner_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mahjamma_matrix_scanner_pkg                                              |
// | Key indices, FSM encoding and row-to-key mapping for the matrix scanner. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mahjamma_matrix_scanner_pkg;

  localparam int KEY_START = 19;
  localparam int KEY_A     = 18;
  localparam int KEY_B     = 17;
  localparam int KEY_C     = 16;
  localparam int KEY_D     = 15;
  localparam int KEY_E     = 14;
  localparam int KEY_F     = 13;
  localparam int KEY_G     = 12;
  localparam int KEY_H     = 11;
  localparam int KEY_I     = 10;
  localparam int KEY_J     = 9;
  localparam int KEY_K     = 8;
  localparam int KEY_L     = 7;
  localparam int KEY_M     = 6;
  localparam int KEY_N     = 5;
  localparam int KEY_CHI   = 4;
  localparam int KEY_PON   = 3;
  localparam int KEY_KAN   = 2;
  localparam int KEY_REACH = 1;
  localparam int KEY_RON   = 0;

  localparam int NUM_KEYS    = 20;
  localparam int NUM_SELECTS = 6;
  localparam int NUM_RETURNS = 4;

  // Row index equals the o_select bit driving that matrix line.
  localparam logic [2:0] ROW_M1  = 3'd0;
  localparam logic [2:0] ROW_M3  = 3'd1;
  localparam logic [2:0] ROW_M4  = 3'd2;
  localparam logic [2:0] ROW_M7  = 3'd3;
  localparam logic [2:0] ROW_M8  = 3'd4;
  localparam logic [2:0] ROW_M11 = 3'd5;
  localparam logic [2:0] LAST_ROW = ROW_M11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_GAP    = 2'd2,
    ST_UPDATE = 2'd3
  } scan_state_e;

  // Places one row's active-high returns into its key slots; unwired positions are dropped.
  function automatic logic [NUM_KEYS-1:0] insert_row(input logic [NUM_KEYS-1:0] frame,
                                                     input logic [2:0] row,
                                                     input logic [NUM_RETURNS-1:0] bits);
    logic [NUM_KEYS-1:0] f;
    f = frame;
    case (row)
      ROW_M1:  f[KEY_KAN:KEY_RON] = bits[3:1];
      ROW_M3:  f[KEY_M:KEY_PON]   = bits;
      ROW_M4:  f[KEY_I:KEY_L]     = bits;
      ROW_M7:  f[KEY_E:KEY_H]     = bits;
      ROW_M8:  f[KEY_A:KEY_D]     = bits;
      ROW_M11: f[KEY_START]       = bits[3];
      default: f = frame;
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mahjamma_sync2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mahjamma_sync2                                                           |
// | Two-flop synchronizer for asynchronous level inputs.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mahjamma_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_nReset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule
`default_nettype wire

// File: rtl/mahjamma_matrix_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mahjamma_matrix_scanner                                                  |
// | Scans a 6x4 key matrix, debounces by 2-frame agreement, reports keys.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mahjamma_matrix_scanner
  import mahjamma_matrix_scanner_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int GAP_CYCLES    = 4
) (
  input  logic                   i_clk,
  input  logic                   i_nReset,
  input  logic                   i_scanEn,
  input  logic                   i_matrixPolarity,
  output logic [NUM_SELECTS-1:0] o_select,
  input  logic [NUM_RETURNS-1:0] i_return,
  output logic [NUM_KEYS-1:0]    o_keys,
  output logic                   o_frame,
  output logic                   o_changed
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] GAP_LAST    = 8'(GAP_CYCLES - 1);

  logic [NUM_RETURNS-1:0] ret_active;
  logic [NUM_RETURNS-1:0] ret_sync;

  // Polarity is static while scanning, so folding it in ahead of the synchronizer
  // lets the reset value of the sync flops mean "no key pressed".
  assign ret_active = i_return ^ {NUM_RETURNS{~i_matrixPolarity}};

  mahjamma_sync2 #(
    .WIDTH (NUM_RETURNS)
  ) u_sync (
    .i_clk    (i_clk),
    .i_nReset (i_nReset),
    .i_d      (ret_active),
    .o_q      (ret_sync)
  );

  scan_state_e         state_q, state_d;
  logic [2:0]          row_q, row_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NUM_KEYS-1:0] raw_q, raw_d;
  logic [NUM_KEYS-1:0] prev_q, prev_d;
  logic [NUM_KEYS-1:0] keys_q, keys_d;
  logic                prev_valid_q, prev_valid_d;
  logic                frame_q, frame_d;
  logic                changed_q, changed_d;

  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      cnt_q        <= '0;
      raw_q        <= '0;
      prev_q       <= '0;
      keys_q       <= '0;
      prev_valid_q <= 1'b0;
      frame_q      <= 1'b0;
      changed_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      raw_q        <= raw_d;
      prev_q       <= prev_d;
      keys_q       <= keys_d;
      prev_valid_q <= prev_valid_d;
      frame_q      <= frame_d;
      changed_q    <= changed_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    cnt_d        = cnt_q;
    raw_d        = raw_q;
    prev_d       = prev_q;
    keys_d       = keys_q;
    prev_valid_d = prev_valid_q;
    frame_d      = 1'b0;
    changed_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_scanEn) begin
          state_d = ST_DRIVE;
          row_d   = '0;
          cnt_d   = '0;
        end
      end

      ST_DRIVE: begin
        if (!i_scanEn) begin
          state_d      = ST_IDLE;
          row_d        = '0;
          cnt_d        = '0;
          prev_valid_d = 1'b0;
        end else if (cnt_q == SETTLE_LAST) begin
          raw_d   = insert_row(raw_q, row_q, ret_sync);
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_GAP: begin
        if (!i_scanEn) begin
          state_d      = ST_IDLE;
          row_d        = '0;
          cnt_d        = '0;
          prev_valid_d = 1'b0;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (row_q == LAST_ROW) begin
            state_d = ST_UPDATE;
          end else begin
            state_d = ST_DRIVE;
            row_d   = row_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_UPDATE: begin
        // Keys only move when two consecutive complete frames agree.
        if (prev_valid_q && (raw_q == prev_q)) begin
          keys_d = raw_q;
        end
        prev_d       = raw_q;
        prev_valid_d = 1'b1;
        frame_d      = 1'b1;
        changed_d    = (keys_d != keys_q);
        row_d        = '0;
        cnt_d        = '0;
        state_d      = i_scanEn ? ST_DRIVE : ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        row_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    o_select = {NUM_SELECTS{~i_matrixPolarity}};
    if (state_q == ST_DRIVE) begin
      o_select[row_q] = i_matrixPolarity;
    end
  end

  assign o_keys    = keys_q;
  assign o_frame   = frame_q;
  assign o_changed = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_mahjamma_matrix_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mahjamma_matrix_scanner                                               |
// | Matrix model + frame scoreboard bench for the key-matrix scanner.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mahjamma_matrix_scanner;
  import mahjamma_matrix_scanner_pkg::*;

  localparam int SETTLE = 16;
  localparam int GAP    = 4;
  localparam int PERIOD = 6 * (SETTLE + GAP) + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en = 1'b0;
  logic        pol = 1'b0;
  logic [5:0]  sel;
  logic [3:0]  ret;
  logic [19:0] keys;
  logic        frame;
  logic        changed;

  logic [19:0] pressed = '0;
  logic [3:0]  noise = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mahjamma_matrix_scanner #(
    .SETTLE_CYCLES (SETTLE),
    .GAP_CYCLES    (GAP)
  ) dut (
    .i_clk            (clk),
    .i_nReset         (rst_n),
    .i_scanEn         (scan_en),
    .i_matrixPolarity (pol),
    .o_select         (sel),
    .i_return         (ret),
    .o_keys           (keys),
    .o_frame          (frame),
    .o_changed        (changed)
  );

  // Physical matrix: which select line and which return line each key sits on.
  function automatic int key_row(input int k);
    if (k == 19) return 5;
    if (k >= 15) return 4;
    if (k >= 11) return 3;
    if (k >= 7)  return 2;
    if (k >= 3)  return 1;
    return 0;
  endfunction

  function automatic int key_col(input int k);
    if (k == 19) return 3;
    if (k >= 15) return k - 15;
    if (k >= 11) return k - 11;
    if (k >= 7)  return k - 7;
    if (k >= 3)  return k - 3;
    return k + 1;
  endfunction

  // Unwired matrix crossings carry random junk that must never reach o_keys.
  function automatic logic [3:0] matrix_return(input logic [5:0] s, input logic [19:0] p,
                                               input logic polarity, input logic [3:0] nz);
    logic [5:0] act;
    logic [3:0] r;
    act = s ^ {6{~polarity}};
    r = '0;
    for (int row = 0; row < 6; row++) begin
      if (act[row]) begin
        for (int k = 0; k < 20; k++) begin
          if (p[k] && key_row(k) == row) r[key_col(k)] = 1'b1;
        end
        if (row == 5) r[2:0] = r[2:0] | nz[2:0];
        if (row == 0) r[0] = r[0] | nz[0];
      end
    end
    return polarity ? r : ~r;
  endfunction

  assign ret = matrix_return(sel, pressed, pol, noise);

  always @(negedge clk) noise = 4'($urandom);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: one entry per frame that should complete.
  typedef struct packed {
    logic [19:0] keys;
    logic        changed;
  } exp_t;
  exp_t exp_q[$];

  logic [19:0] m_keys = '0;
  logic [19:0] m_last = '0;
  logic        m_last_ok = 1'b0;

  task automatic push_frame(input logic [19:0] seen);
    exp_t e;
    e.changed = 1'b0;
    if (m_last_ok && seen == m_last && seen != m_keys) begin
      m_keys    = seen;
      e.changed = 1'b1;
    end
    m_last    = seen;
    m_last_ok = 1'b1;
    e.keys    = m_keys;
    exp_q.push_back(e);
  endtask

  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (frame) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_frame: got o_frame=1, expected no frame at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("frame_keys", 32'(keys), 32'(mon_e.keys));
        check("frame_changed", 32'(changed), 32'(mon_e.changed));
      end
    end else if (changed) begin
      n_cmp++;
      n_err++;
      $display("FAIL changed_without_frame: got o_changed=1, expected 0 at %0t", $time);
    end
  end

  // Select-line shape tracker: run lengths, one-hot, row order.
  logic       sel_chk = 1'b0;
  logic       t_first = 1'b1;
  logic       t_act = 1'b0;
  logic       t_skip = 1'b1;
  logic       t_have_exp = 1'b0;
  int         t_row = 0;
  int         t_len = 0;
  int         t_exp = 0;
  logic [5:0] t_a;
  int         t_r;
  logic       t_now;

  always @(posedge clk) begin
    #1;
    if (!sel_chk) begin
      t_first = 1'b1;
    end else begin
      t_a = sel ^ {6{~pol}};
      if ((t_a & (t_a - 6'd1)) != 6'd0) begin
        n_cmp++;
        n_err++;
        $display("FAIL select_onehot: got 0x%0h, expected at most one active line", sel);
      end
      t_now = (t_a != 6'd0);
      t_r = 0;
      for (int i = 0; i < 6; i++) if (t_a[i]) t_r = i;
      if (t_first) begin
        t_first = 1'b0;
        t_act = t_now; t_row = t_r; t_len = 1; t_skip = 1'b1; t_have_exp = 1'b0;
      end else if (t_now == t_act && (!t_now || t_r == t_row)) begin
        t_len++;
      end else begin
        if (!t_skip) begin
          if (t_act) begin
            check("settle_len", 32'(t_len), 32'(SETTLE));
          end else begin
            check("gap_len", 32'(t_len), 32'((t_r == 0) ? GAP + 1 : GAP));
            if (t_have_exp) check("row_order", 32'(t_r), 32'(t_exp));
          end
        end
        if (t_act) begin
          t_exp = (t_row + 1) % 6;
          t_have_exp = 1'b1;
        end
        t_skip = 1'b0;
        t_act = t_now; t_row = t_r; t_len = 1;
      end
    end
  end

  task automatic wait_frame(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!frame && cycles < 400);
    if (!frame) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame_timeout: got no o_frame in %0d cycles, expected one", cycles);
    end
  endtask

  task automatic run_frame(input logic [19:0] p, input int exp_period);
    int c;
    pressed = p;
    push_frame(p);
    wait_frame(c);
    if (exp_period != 0) check("frame_period", 32'(c), 32'(exp_period));
  endtask

  task automatic start_scan();
    scan_en = 1'b1;
    sel_chk = 1'b1;
  endtask

  task automatic stop_scan();
    sel_chk   = 1'b0;
    scan_en   = 1'b0;
    m_last_ok = 1'b0;
  endtask

  task automatic wait_row(input int row, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < 300 && !ok) begin
      @(negedge clk);
      n++;
      ok = ((sel ^ {6{~pol}}) == 6'(1 << row));
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_row%0d: got no active row %0d, expected one within 300 cycles", row, row);
    end
  endtask

  task automatic wait_idle_sel(output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < 300 && !ok) begin
      @(negedge clk);
      n++;
      ok = (sel == {6{~pol}});
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_gap: got select 0x%0h, expected inactive within 300 cycles", sel);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected bench to complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [19:0] p;
    logic [19:0] q;
    bit ok;

    // Reset values, under both polarities.
    repeat (3) @(negedge clk);
    check("rst_select_pol0", 32'(sel), 32'h3f);
    check("rst_keys", 32'(keys), 32'h0);
    check("rst_frame", 32'(frame), 32'h0);
    check("rst_changed", 32'(changed), 32'h0);
    pol = 1'b1;
    #1 check("rst_select_pol1", 32'(sel), 32'h00);
    pol = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_select", 32'(sel), 32'h3f);

    // Empty matrix, active-low.
    start_scan();
    run_frame(20'h0, PERIOD + 1);
    run_frame(20'h0, PERIOD);
    run_frame(20'h0, PERIOD);

    // START + RON: latch on the second agreeing frame, silent third.
    p = '0;
    p[KEY_START] = 1'b1;
    p[KEY_RON]   = 1'b1;
    run_frame(p, PERIOD);
    run_frame(p, PERIOD);
    check("start_ron_keys", 32'(keys), 32'h80001);
    run_frame(p, PERIOD);

    // One key flickering on alternate frames must never propagate.
    q = p;
    q[KEY_E] = 1'b1;
    for (int i = 0; i < 4; i++) run_frame((i % 2 == 0) ? q : p, PERIOD);
    check("toggle_hold", 32'(keys), 32'h80001);

    // Random patterns held for 1..3 frames.
    for (int i = 0; i < 6; i++) begin
      p = 20'($urandom);
      repeat ($urandom_range(1, 3)) run_frame(p, PERIOD);
    end

    // Drop enable in the middle of row 3.
    pressed = 20'($urandom);
    wait_row(3, ok);
    repeat ($urandom_range(0, 8)) @(negedge clk);
    sel_chk = 1'b0;
    scan_en = 1'b0;
    m_last_ok = 1'b0;
    @(posedge clk);
    #1 check("drop_select", 32'(sel), 32'h3f);
    repeat (150) @(negedge clk);
    check("drop_keys_held", 32'(keys), 32'(m_keys));
    q = 20'($urandom) | 20'h00100;
    if (q == m_keys) q = ~q;
    start_scan();
    run_frame(q, PERIOD + 1);
    check("restart_first_hold", 32'(keys), 32'(m_keys));
    run_frame(q, PERIOD);
    check("restart_update", 32'(keys), 32'(q));

    // Active-high matrix, CHI only.
    stop_scan();
    repeat (4) @(negedge clk);
    pol = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_select_pol1", 32'(sel), 32'h00);
    p = '0;
    p[KEY_CHI] = 1'b1;
    start_scan();
    run_frame(p, PERIOD + 1);
    run_frame(p, PERIOD);
    check("chi_keys", 32'(keys), 32'h00010);
    for (int i = 0; i < 3; i++) begin
      p = 20'($urandom);
      repeat ($urandom_range(1, 3)) run_frame(p, PERIOD);
    end

    // Asynchronous reset in the row-2 gap with keys latched.
    p = 20'($urandom) | 20'h00001;
    run_frame(p, PERIOD);
    run_frame(p, PERIOD);
    wait_row(2, ok);
    wait_idle_sel(ok);
    check("keys_latched", 32'(keys), 32'(m_keys));
    sel_chk = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_keys", 32'(keys), 32'h0);
    check("async_rst_select", 32'(sel), 32'({6{~pol}}));
    exp_q.delete();
    m_keys = '0;
    m_last = '0;
    m_last_ok = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sel_chk = 1'b1;
    run_frame(p, PERIOD + 1);
    check("post_rst_hold", 32'(keys), 32'h0);
    run_frame(p, PERIOD);
    check("post_rst_update", 32'(keys), 32'(p));

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
